// File: rtl/fp_sub_pipe.sv
// Pipelined binary16 subtractor, diff = opA - opB (RNE, subnormals flushed to zero); optional flags port under FP_SUB_FLAGS_EN.
// Latency: 3 cycles accept->out_valid (unpack/align, add/sub, normalise/round); one result per cycle.
// Backpressure: global stall when out_valid && !out_ready; every stage holds and in_ready drops.
module fp_sub_pipe (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff
`ifdef FP_SUB_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  // ---------------------------------------------------------------- control
  logic r_out_vld;
  logic w_stall;

  assign w_stall  = r_out_vld & ~out_ready;
  assign in_ready = ~w_stall;

  // ---------------------------------------------------------------- stage 1: unpack, swap, align
  logic [4:0]  w_ea, w_eb, w_ex, w_ey, w_d;
  logic [9:0]  w_fa, w_fb, w_fx, w_fy;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic        w_sbn, w_swap, w_sx, w_sy;
  logic [10:0] w_mx, w_my;
  logic [23:0] w_y_ext;
  logic [13:0] w_y_al;
  logic        w_spec;
  logic [15:0] w_spec_val;

  // Subnormal operands lose their fraction here, so they behave as signed zero.
  assign w_ea    = opA[14:10];
  assign w_eb    = opB[14:10];
  assign w_fa    = (w_ea == 5'd0) ? 10'd0 : opA[9:0];
  assign w_fb    = (w_eb == 5'd0) ? 10'd0 : opB[9:0];
  assign w_a_nan = (w_ea == 5'h1f) && (opA[9:0] != 10'd0);
  assign w_b_nan = (w_eb == 5'h1f) && (opB[9:0] != 10'd0);
  assign w_a_inf = (w_ea == 5'h1f) && (opA[9:0] == 10'd0);
  assign w_b_inf = (w_eb == 5'h1f) && (opB[9:0] == 10'd0);
  assign w_sbn   = ~opB[15];

  // X is always the operand of larger magnitude; ties keep opA as X.
  assign w_swap = {w_eb, w_fb} > {w_ea, w_fa};
  assign w_ex   = w_swap ? w_eb : w_ea;
  assign w_ey   = w_swap ? w_ea : w_eb;
  assign w_fx   = w_swap ? w_fb : w_fa;
  assign w_fy   = w_swap ? w_fa : w_fb;
  assign w_sx   = w_swap ? w_sbn : opA[15];
  assign w_sy   = w_swap ? opA[15] : w_sbn;
  assign w_mx   = {(w_ex != 5'd0), w_fx};
  assign w_my   = {(w_ey != 5'd0), w_fy};
  assign w_d    = w_ex - w_ey;

  // Y aligned as {mant[10:0], guard, round, sticky}; beyond 12 places only the sticky survives.
  assign w_y_ext = {w_my, 13'd0} >> w_d;
  assign w_y_al  = (w_d >= 5'd13) ? {13'd0, |w_my}
                                  : {w_y_ext[23:11], |w_y_ext[10:0]};

  // NaN and infinity operands bypass the arithmetic with a precomputed result.
  always_comb begin
    w_spec     = 1'b1;
    w_spec_val = 16'h7e00;
    if (w_a_nan || w_b_nan) begin
      w_spec_val = 16'h7e00;
    end else if (w_a_inf && w_b_inf && (opA[15] == opB[15])) begin
      w_spec_val = 16'h7e00;
    end else if (w_a_inf) begin
      w_spec_val = opA;
    end else if (w_b_inf) begin
      w_spec_val = {w_sbn, 15'h7c00};
    end else begin
      w_spec = 1'b0;
    end
  end

  logic        r_s1_vld, r_s1_spec, r_s1_sx, r_s1_sub;
  logic [15:0] r_s1_spec_val;
  logic [4:0]  r_s1_ex;
  logic [10:0] r_s1_xm;
  logic [13:0] r_s1_ym;

  // Stage 1 register: capture the aligned operand pair.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_vld      <= 1'b0;
      r_s1_spec     <= 1'b0;
      r_s1_spec_val <= 16'h0000;
      r_s1_sx       <= 1'b0;
      r_s1_sub      <= 1'b0;
      r_s1_ex       <= 5'd0;
      r_s1_xm       <= 11'd0;
      r_s1_ym       <= 14'd0;
    end else if (!w_stall) begin
      r_s1_vld      <= in_valid;
      r_s1_spec     <= w_spec;
      r_s1_spec_val <= w_spec_val;
      r_s1_sx       <= w_sx;
      r_s1_sub      <= (w_sx != w_sy);
      r_s1_ex       <= w_ex;
      r_s1_xm       <= w_mx;
      r_s1_ym       <= w_y_al;
    end
  end

  // ---------------------------------------------------------------- stage 2: mantissa add/sub
  logic [14:0] w_sum;

  // |X| >= |Y| so the effective subtraction never goes negative.
  assign w_sum = r_s1_sub ? ({1'b0, r_s1_xm, 3'b000} - {1'b0, r_s1_ym})
                          : ({1'b0, r_s1_xm, 3'b000} + {1'b0, r_s1_ym});

  logic        r_s2_vld, r_s2_spec, r_s2_sx, r_s2_sub;
  logic [15:0] r_s2_spec_val;
  logic [4:0]  r_s2_ex;
  logic [14:0] r_s2_sum;

  // Stage 2 register: raw sum with carry and G/R/S bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2_vld      <= 1'b0;
      r_s2_spec     <= 1'b0;
      r_s2_spec_val <= 16'h0000;
      r_s2_sx       <= 1'b0;
      r_s2_sub      <= 1'b0;
      r_s2_ex       <= 5'd0;
      r_s2_sum      <= 15'd0;
    end else if (!w_stall) begin
      r_s2_vld      <= r_s1_vld;
      r_s2_spec     <= r_s1_spec;
      r_s2_spec_val <= r_s1_spec_val;
      r_s2_sx       <= r_s1_sx;
      r_s2_sub      <= r_s1_sub;
      r_s2_ex       <= r_s1_ex;
      r_s2_sum      <= w_sum;
    end
  end

  // ---------------------------------------------------------------- stage 3: normalise, round, pack
  logic [3:0]        w_lz;
  logic [13:0]       w_norm;
  logic [10:0]       w_mant;
  logic              w_rb, w_st, w_inc;
  logic [11:0]       w_mr;
  logic [9:0]        w_frac;
  logic signed [6:0] w_e, w_ef;
  logic [15:0]       w_res;

  // Normalise, round to nearest-even, then resolve zero/underflow/overflow/specials.
  always_comb begin
    w_lz = 4'd0;
    for (int i = 0; i < 14; i++) begin
      if (r_s2_sum[i]) w_lz = 4'(13 - i);
    end
    w_norm = r_s2_sum[13:0] << w_lz;
    if (r_s2_sum[14]) begin
      w_mant = r_s2_sum[14:4];
      w_rb   = r_s2_sum[3];
      w_st   = |r_s2_sum[2:0];
      w_e    = $signed({2'b00, r_s2_ex}) + 7'sd1;
    end else begin
      w_mant = w_norm[13:3];
      w_rb   = w_norm[2];
      w_st   = |w_norm[1:0];
      w_e    = $signed({2'b00, r_s2_ex}) - $signed({3'b000, w_lz});
    end
    w_inc  = w_rb & (w_st | w_mant[0]);
    w_mr   = {1'b0, w_mant} + {11'd0, w_inc};
    w_frac = w_mr[11] ? w_mr[10:1] : w_mr[9:0];
    w_ef   = w_mr[11] ? (w_e + 7'sd1) : w_e;
    if (r_s2_spec) begin
      w_res = r_s2_spec_val;
    end else if (r_s2_sum == 15'd0) begin
      // Exact cancellation is +0; adding two zeros keeps their common sign.
      w_res = r_s2_sub ? 16'h0000 : {r_s2_sx, 15'h0000};
    end else if (w_ef <= 7'sd0) begin
      w_res = 16'h0000;
    end else if (w_ef > 7'sd30) begin
      w_res = {r_s2_sx, 15'h7c00};
    end else begin
      w_res = {r_s2_sx, w_ef[4:0], w_frac};
    end
  end

  logic [15:0] r_diff;
`ifdef FP_SUB_FLAGS_EN
  logic [2:0]  r_flags;
`endif

  // Output register: result only updates when a valid op moves in, so it stays put under stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_vld <= 1'b0;
      r_diff    <= 16'h0000;
`ifdef FP_SUB_FLAGS_EN
      r_flags   <= 3'b000;
`endif
    end else if (!w_stall) begin
      r_out_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_diff  <= w_res;
`ifdef FP_SUB_FLAGS_EN
        r_flags <= {(~r_s2_spec & (w_res[14:0] == 15'h7c00)),
                    (w_res[15] & ~((w_res[14:10] == 5'h1f) && (w_res[9:0] != 10'd0))),
                    (w_res[14:0] == 15'd0)};
`endif
      end
    end
  end

  assign out_valid = r_out_vld;
  assign diff      = r_diff;
`ifdef FP_SUB_FLAGS_EN
  assign flags     = r_flags;
`endif

endmodule

// File: tb/tb_fp_sub_pipe.sv
// Self-checking bench for fp_sub_pipe: directed table, latency/backpressure/reset sequences,
// and random streaming against an exact-integer reference model.
module tb_fp_sub_pipe;

  logic        clock, reset, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] opA, opB, diff;
`ifdef FP_SUB_FLAGS_EN
  logic [2:0]  flags;
`endif

  fp_sub_pipe dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .opA(opA), .opB(opB),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff)
`ifdef FP_SUB_FLAGS_EN
    , .flags(flags)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed { logic [15:0] d; logic [2:0] f; } exp_t;
  typedef struct packed { logic [15:0] a; logic [15:0] b; logic [15:0] d; } vec_t;

  int   errors = 0, checks = 0, nrecv = 0, n_ticks = 0;
  exp_t exp_q[$];
  exp_t pend;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: operands become exact signed integers scaled by 2^24, subtract, then round the
  // magnitude to 11 significant bits (nearest, ties to even) and re-encode with flush-to-zero.
  function automatic logic [15:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, p, e, sh;
    longint va, vb, d, mag, q, rem, half;
    logic s;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0)) return 16'h7e00;
    if (ea == 31 && eb == 31) return (a[15] == b[15]) ? 16'h7e00 : a;
    if (ea == 31) return a;
    if (eb == 31) return {~b[15], 15'h7c00};
    va = (ea == 0) ? 0 : (longint'(1024 + int'(a[9:0])) <<< (ea - 1));
    vb = (eb == 0) ? 0 : (longint'(1024 + int'(b[9:0])) <<< (eb - 1));
    if (va == 0 && vb == 0) return {a[15] & ~b[15], 15'h0000};
    if (a[15]) va = -va;
    if (b[15]) vb = -vb;
    d = va - vb;
    if (d == 0) return 16'h0000;
    s   = (d < 0);
    mag = s ? -d : d;
    p = 0;
    for (int i = 0; i < 48; i++) if (mag[i]) p = i;
    e = p - 9;
    if (p >= 10) begin
      sh = p - 10;
      q  = mag >> sh;
      if (sh > 0) begin
        rem  = mag - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
      end
      if (q == 2048) begin q = 1024; e++; end
    end else begin
      q = mag << (10 - p);
    end
    if (e <= 0) return 16'h0000;
    if (e > 30) return {s, 15'h7c00};
    return {s, 5'(e), 10'(q)};
  endfunction

  function automatic logic [2:0] ref_flags(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r);
    logic ovf, neg, zer;
    ovf = (a[14:10] != 5'h1f) && (b[14:10] != 5'h1f) && (r[14:0] == 15'h7c00);
    neg = r[15] && !((r[14:10] == 5'h1f) && (r[9:0] != 0));
    zer = (r[14:0] == 15'd0);
    return {ovf, neg, zer};
  endfunction

  function automatic logic [15:0] rnd_norm(input int e);
    return {1'($urandom_range(1, 0)), 5'(e), 10'($urandom)};
  endfunction

  // One clock: evaluate both handshakes just before the edge, then move to the next falling edge.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h, expected no output", diff);
      end else begin
        e = exp_q.pop_front();
        nrecv++;
        chk("stream_diff", diff, e.d);
`ifdef FP_SUB_FLAGS_EN
        chk("stream_flags", {13'd0, flags}, {13'd0, e.f});
`endif
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(pend);
      acc = 1'b1;
    end
    n_ticks++;
    @(negedge clock);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] d);
    bit acc;
    int n;
    in_valid = 1'b1; opA = a; opB = b;
    pend.d = d; pend.f = ref_flags(a, b, d);
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin tick(acc); n++; end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready=%b, required 1", in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid = 1'b0; n = 0;
    while (exp_q.size() > 0 && n < 50) begin tick(acc); n++; end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Single op into an empty pipe: out_valid must rise after exactly the third rising edge.
  task automatic latency_check(input logic [15:0] a, input logic [15:0] b, input logic [15:0] d);
    out_ready = 1'b1; in_valid = 1'b1; opA = a; opB = b;
    #1 chk("lat_in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clock); in_valid = 1'b0;
    chk("lat_vld_c1", {15'd0, out_valid}, 16'd0);
    @(negedge clock);
    chk("lat_vld_c2", {15'd0, out_valid}, 16'd0);
    @(negedge clock);
    chk("lat_vld_c3", {15'd0, out_valid}, 16'd1);
    chk("lat_diff", diff, d);
    @(negedge clock);
    chk("lat_vld_c4", {15'd0, out_valid}, 16'd0);
  endtask

  vec_t        vecs[17];
  logic [15:0] bpa[4], bpb[4], first, ra, rb;
  int          r0, ea, eb;

  initial begin
    vecs[0]  = '{16'h4000, 16'h3c00, 16'h3c00};
    vecs[1]  = '{16'h3c00, 16'h4000, 16'hbc00};
    vecs[2]  = '{16'h3c00, 16'h3c00, 16'h0000};
    vecs[3]  = '{16'h380a, 16'h37dc, 16'h2300};
    vecs[4]  = '{16'h8000, 16'h0000, 16'h8000};
    vecs[5]  = '{16'h7bff, 16'hfbff, 16'h7c00};
    vecs[6]  = '{16'h7c00, 16'h7c00, 16'h7e00};
    vecs[7]  = '{16'h7e01, 16'h3c00, 16'h7e00};
    vecs[8]  = '{16'h0001, 16'h0000, 16'h0000};
    vecs[9]  = '{16'h6c00, 16'h3c00, 16'h6c00};
    vecs[10] = '{16'h3c00, 16'h7c00, 16'hfc00};
    vecs[11] = '{16'hfc00, 16'h7c00, 16'hfc00};
    vecs[12] = '{16'h8000, 16'h8000, 16'h0000};
    vecs[13] = '{16'h7c00, 16'h3c00, 16'h7c00};
    vecs[14] = '{16'h3c00, 16'hbc00, 16'h4000};
    vecs[15] = '{16'h0400, 16'h0001, 16'h0400};
    vecs[16] = '{16'h0401, 16'h0400, 16'h0000};

    reset = 1'b1; in_valid = 1'b0; opA = 16'h0; opB = 16'h0; out_ready = 1'b1;
    pend = '0;
    repeat (3) @(negedge clock);
    chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
    chk("reset_diff", diff, 16'h0000);
`ifdef FP_SUB_FLAGS_EN
    chk("reset_flags", {13'd0, flags}, 16'd0);
`endif
    reset = 1'b0;
    @(negedge clock);
    chk("in_ready_after_reset", {15'd0, in_ready}, 16'd1);

    latency_check(16'h4000, 16'h3c00, 16'h3c00);

    // Directed table, issued back to back.
    out_ready = 1'b1;
    foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].d);
    drain();

    // Backpressure: three ops fill the pipe, a fourth waits while the output is held.
    for (int i = 0; i < 4; i++) begin
      bpa[i] = rnd_norm($urandom_range(30, 1));
      bpb[i] = rnd_norm($urandom_range(30, 1));
    end
    first = ref_sub(bpa[0], bpb[0]);
    r0 = nrecv;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(bpa[i], bpb[i], ref_sub(bpa[i], bpb[i]));
    in_valid = 1'b1; opA = bpa[3]; opB = bpb[3];
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
      chk("bp_out_valid", {15'd0, out_valid}, 16'd1);
      chk("bp_hold", diff, first);
      @(negedge clock);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    issue(bpa[3], bpb[3], ref_sub(bpa[3], bpb[3]));
    drain();
    chk("bp_count", 16'(nrecv - r0), 16'd4);

    // Random streaming, half the pairs with equal exponents to stress cancellation.
    r0 = nrecv;
    n_ticks = 0;
    for (int i = 0; i < 100; i++) begin
      ea = $urandom_range(30, 1);
      eb = ($urandom_range(1, 0) == 1) ? ea : $urandom_range(30, 1);
      ra = rnd_norm(ea);
      rb = rnd_norm(eb);
      issue(ra, rb, ref_sub(ra, rb));
    end
    chk("stream_rate", 16'(n_ticks), 16'd100);
    drain();
    chk("stream_count", 16'(nrecv - r0), 16'd100);

    // Reset with three ops in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ra = rnd_norm($urandom_range(30, 1));
      rb = rnd_norm($urandom_range(30, 1));
      issue(ra, rb, ref_sub(ra, rb));
    end
    reset = 1'b1;
    #1;
    chk("midreset_out_valid", {15'd0, out_valid}, 16'd0);
    chk("midreset_diff", diff, 16'h0000);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midreset_in_ready", {15'd0, in_ready}, 16'd1);
    latency_check(16'h3c00, 16'h4000, 16'hbc00);
    repeat (4) begin
      #1;
      chk("post_reset_quiet", {15'd0, out_valid}, 16'd0);
      @(negedge clock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
